// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared types and bus constants for I2C target blocks
package i2c_target_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_MACK,
      ST_WAIT_P
   } i2c_state_e;

   localparam logic [6:0] DEF_DEV_ADDR = 7'h48;
   localparam logic       RW_WRITE     = 1'b0;
   localparam logic       RW_READ      = 1'b1;
   localparam logic       ACK          = 1'b0;
   localparam logic       NACK         = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronisers with registered edge and START/STOP strobes
module i2c_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic scl,
   input  logic sda_in,
   output logic sda_sync,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [1:0] scl_ff;
   logic [1:0] sda_ff;
   logic       scl_d;
   logic       sda_d;

   // Idle bus is high, so reset everything to 1 to avoid a false edge on release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_ff    <= 2'b11;
         sda_ff    <= 2'b11;
         scl_d     <= 1'b1;
         sda_d     <= 1'b1;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
      end else begin
         scl_ff    <= {scl_ff[0], scl};
         sda_ff    <= {sda_ff[0], sda_in};
         scl_d     <= scl_ff[1];
         sda_d     <= sda_ff[1];
         scl_rise  <= scl_ff[1] & ~scl_d;
         scl_fall  <= ~scl_ff[1] & scl_d;
         start_det <= scl_ff[1] & scl_d & sda_d & ~sda_ff[1];
         stop_det  <= scl_ff[1] & scl_d & ~sda_d & sda_ff[1];
      end
   end

   assign sda_sync = sda_d;

endmodule

// File: rtl/i2c_reg_target.sv
// rtl/i2c_reg_target.sv - oversampled I2C target serving a pointer-addressed multi-byte register bank
module i2c_reg_target
   import i2c_target_pkg::*;
#(
   parameter logic [6:0]                         DEV_ADDR  = DEF_DEV_ADDR,
   parameter int                                 NUM_REGS  = 4,
   parameter int                                 REG_BYTES = 2,
   parameter logic [NUM_REGS*REG_BYTES*8-1:0]    REG_INIT  = 64'h0000_0000_61A0_2720,
   parameter logic [NUM_REGS-1:0]                RO_MASK   = 4'b0001,
   localparam int                                PW        = $clog2(NUM_REGS),
   localparam int                                W         = 8*REG_BYTES
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          scl,
   input  logic          sda_in,
   output logic          sda_oe,
   input  logic          hw_upd_en,
   input  logic [PW-1:0] hw_upd_idx,
   input  logic [W-1:0]  hw_upd_data,
   output logic          reg_wr_stb,
   output logic [PW-1:0] reg_wr_idx,
   output logic [W-1:0]  reg_wr_data,
   output logic          busy
);

   logic sda_sync, scl_rise, scl_fall, start_det, stop_det;

   i2c_line_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl       (scl),
      .sda_in    (sda_in),
      .sda_sync  (sda_sync),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   i2c_state_e    state;
   logic [2:0]    bit_cnt;
   logic [6:0]    shreg;
   logic          rw;
   logic [PW-1:0] ptr;
   logic [1:0]    byte_idx;
   logic [W-1:0]  shadow;
   logic [W-1:0]  txw;
   logic [W-1:0]  regs [NUM_REGS];

   logic [7:0]    rx_byte;
   logic [W-1:0]  sh_next;
   logic [W-1:0]  rd_cur;
   logic [PW-1:0] ptr_inc;
   logic          last_byte;

   assign rx_byte   = {shreg, sda_sync};
   assign sh_next   = (shadow << 8) | W'(rx_byte);
   assign last_byte = (byte_idx == 2'(REG_BYTES - 1));
   assign ptr_inc   = (32'(ptr) == NUM_REGS - 1) ? '0 : ptr + 1'b1;
   // The snapshot is taken only at bit 0 of byte 0, so a multi-byte read is atomic.
   assign rd_cur    = (bit_cnt == 3'd0 && byte_idx == 2'd0) ? regs[ptr] : txw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         shreg       <= '0;
         rw          <= RW_WRITE;
         ptr         <= '0;
         byte_idx    <= '0;
         shadow      <= '0;
         txw         <= '0;
         sda_oe      <= 1'b0;
         busy        <= 1'b0;
         reg_wr_stb  <= 1'b0;
         reg_wr_idx  <= '0;
         reg_wr_data <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_INIT[i*W +: W];
      end else begin
         reg_wr_stb <= 1'b0;
         if (hw_upd_en && RO_MASK[hw_upd_idx]) regs[hw_upd_idx] <= hw_upd_data;

         if (start_det) begin
            state    <= ST_ADDR;
            bit_cnt  <= '0;
            byte_idx <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b1;
         end else if (stop_det) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_idx <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
         end else if (scl_fall) begin
            case (state)
               ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: sda_oe <= ~ACK;
               ST_RDATA: begin
                  sda_oe <= ~rd_cur[W-1];
                  txw    <= rd_cur << 1;
               end
               default: sda_oe <= 1'b0;
            endcase
         end else if (scl_rise) begin
            case (state)
               ST_ADDR: begin
                  shreg   <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     if (rx_byte[7:1] == DEV_ADDR) begin
                        rw    <= rx_byte[0];
                        state <= ST_ADDR_ACK;
                     end else begin
                        state <= ST_WAIT_P;
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  bit_cnt <= '0;
                  state   <= (rw == RW_READ) ? ST_RDATA : ST_PTR;
               end
               ST_PTR: begin
                  shreg   <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     if ({24'd0, rx_byte} < NUM_REGS) begin
                        ptr      <= rx_byte[PW-1:0];
                        byte_idx <= '0;
                        state    <= ST_PTR_ACK;
                     end else begin
                        state <= ST_WAIT_P;
                     end
                  end
               end
               ST_PTR_ACK, ST_WDATA_ACK: begin
                  bit_cnt <= '0;
                  state   <= ST_WDATA;
               end
               ST_WDATA: begin
                  shreg   <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     shadow <= sh_next;
                     state  <= ST_WDATA_ACK;
                     if (last_byte) begin
                        byte_idx <= '0;
                        ptr      <= ptr_inc;
                        if (!RO_MASK[ptr]) begin
                           regs[ptr]   <= sh_next;
                           reg_wr_stb  <= 1'b1;
                           reg_wr_idx  <= ptr;
                           reg_wr_data <= sh_next;
                        end
                     end else begin
                        byte_idx <= byte_idx + 1'b1;
                     end
                  end
               end
               ST_RDATA: begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= ST_MACK;
               end
               ST_MACK: begin
                  bit_cnt <= '0;
                  if (sda_sync == ACK) begin
                     state <= ST_RDATA;
                     if (last_byte) begin
                        byte_idx <= '0;
                        ptr      <= ptr_inc;
                     end else begin
                        byte_idx <= byte_idx + 1'b1;
                     end
                  end else begin
                     state <= ST_WAIT_P;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_reg_target.sv
// tb/tb_i2c_reg_target.sv - bus-master bench with scoreboard queues for ACKs, read data and commits
module tb_i2c_reg_target;

   localparam int Q = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scl = 1'b1;
   logic        sda_m = 1'b1;
   logic        hw_upd_en = 1'b0;
   logic [1:0]  hw_upd_idx = 2'd0;
   logic [15:0] hw_upd_data = 16'd0;
   logic        sda_oe;
   logic        reg_wr_stb;
   logic [1:0]  reg_wr_idx;
   logic [15:0] reg_wr_data;
   logic        busy;
   wire         sda_line = sda_m & ~sda_oe;

   int          n_chk = 0;
   int          n_pass = 0;
   int          oe_cnt = 0;
   int          oe_base;
   logic [31:0] exp_q [$];
   logic [31:0] wr_q [$];
   logic [31:0] wr_exp;

   always #5 clk = ~clk;

   i2c_reg_target dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .scl         (scl),
      .sda_in      (sda_line),
      .sda_oe      (sda_oe),
      .hw_upd_en   (hw_upd_en),
      .hw_upd_idx  (hw_upd_idx),
      .hw_upd_data (hw_upd_data),
      .reg_wr_stb  (reg_wr_stb),
      .reg_wr_idx  (reg_wr_idx),
      .reg_wr_data (reg_wr_data),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (sda_oe) oe_cnt++;
      if (reg_wr_stb) begin
         wr_exp = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hDEAD_BEEF;
         check("wr_commit", {14'd0, reg_wr_idx, reg_wr_data}, wr_exp);
      end
   end

   task automatic wbit(input logic b);
      sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
   endtask

   task automatic rbit(output logic b);
      sda_m = 1'b1; #Q; scl = 1'b1; #Q; b = sda_line; #Q; scl = 1'b0; #Q;
   endtask

   task automatic start_c();
      sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
   endtask

   task automatic stop_c();
      sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
   endtask

   task automatic wbyte(input string tag, input logic [7:0] b, input logic exp_ack);
      logic a;
      exp_q.push_back({31'd0, exp_ack});
      for (int i = 7; i >= 0; i--) wbit(b[i]);
      rbit(a);
      check(tag, {31'd0, a}, exp_q.pop_front());
   endtask

   task automatic rbyte(input string tag, input logic [7:0] exp_b, input logic nack);
      logic [7:0] d;
      logic       bb;
      exp_q.push_back({24'd0, exp_b});
      for (int i = 7; i >= 0; i--) begin
         rbit(bb);
         d[i] = bb;
      end
      wbit(nack);
      check(tag, {24'd0, d}, exp_q.pop_front());
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #52;
      check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_wr_stb", {31'd0, reg_wr_stb}, 32'd0);
      check("rst_wr_idx_data", {14'd0, reg_wr_idx, reg_wr_data}, 32'd0);
      rst_n = 1'b1;
      #(2*Q);

      // pointer 3, read across the wrap into register 0
      start_c();
      check("busy_after_start", {31'd0, busy}, 32'd1);
      wbyte("wrap_addr_w", 8'h90, 1'b0);
      wbyte("wrap_ptr3", 8'h03, 1'b0);
      start_c();
      wbyte("wrap_addr_r", 8'h91, 1'b0);
      rbyte("wrap_r3_b0", 8'h00, 1'b0);
      rbyte("wrap_r3_b1", 8'h00, 1'b0);
      rbyte("wrap_r0_b0", 8'h27, 1'b0);
      rbyte("wrap_r0_b1", 8'h20, 1'b1);
      stop_c();

      // RW write to register 1, then read it back
      wr_q.push_back({14'd0, 2'd1, 16'h1234});
      start_c();
      wbyte("w1_addr", 8'h90, 1'b0);
      wbyte("w1_ptr", 8'h01, 1'b0);
      wbyte("w1_d0", 8'h12, 1'b0);
      wbyte("w1_d1", 8'h34, 1'b0);
      stop_c();
      start_c();
      wbyte("r1_addr_w", 8'h90, 1'b0);
      wbyte("r1_ptr", 8'h01, 1'b0);
      start_c();
      wbyte("r1_addr_r", 8'h91, 1'b0);
      rbyte("r1_b0", 8'h12, 1'b0);
      rbyte("r1_b1", 8'h34, 1'b1);
      stop_c();

      // hw update of RO reg0 lands; update of RW reg1 is ignored
      @(negedge clk);
      hw_upd_en = 1'b1; hw_upd_idx = 2'd0; hw_upd_data = 16'h1950;
      @(negedge clk);
      hw_upd_idx = 2'd1; hw_upd_data = 16'hBEEF;
      @(negedge clk);
      hw_upd_en = 1'b0;
      #3;
      start_c();
      wbyte("hw_addr_w", 8'h90, 1'b0);
      wbyte("hw_ptr0", 8'h00, 1'b0);
      start_c();
      wbyte("hw_addr_r", 8'h91, 1'b0);
      rbyte("hw_r0_b0", 8'h19, 1'b0);
      rbyte("hw_r0_b1", 8'h50, 1'b1);
      check("hw_sda_released", {31'd0, sda_oe}, 32'd0);
      check("hw_busy_before_p", {31'd0, busy}, 32'd1);
      stop_c();
      check("hw_busy_after_p", {31'd0, busy}, 32'd0);

      // foreign address: NACK, SDA never driven, pointer untouched
      oe_base = oe_cnt;
      start_c();
      wbyte("bad_addr_nack", 8'h94, 1'b1);
      wbyte("bad_addr_data", 8'h00, 1'b1);
      stop_c();
      check("bad_addr_no_oe", oe_cnt - oe_base, 32'd0);
      start_c();
      wbyte("ptr_keep_addr", 8'h91, 1'b0);
      rbyte("ptr_keep_r0", 8'h19, 1'b1);
      stop_c();

      // out-of-range pointer is NACKed and leaves the previous pointer
      start_c();
      wbyte("oor_addr0", 8'h90, 1'b0);
      wbyte("oor_ptr1", 8'h01, 1'b0);
      stop_c();
      start_c();
      wbyte("oor_addr1", 8'h90, 1'b0);
      wbyte("oor_ptr7_nack", 8'h07, 1'b1);
      stop_c();
      start_c();
      wbyte("oor_addr_r", 8'h91, 1'b0);
      rbyte("oor_r1_b0", 8'h12, 1'b0);
      rbyte("oor_r1_b1", 8'h34, 1'b1);
      stop_c();

      // write to RO reg0 is ACKed but discarded
      start_c();
      wbyte("ro_addr", 8'h90, 1'b0);
      wbyte("ro_ptr0", 8'h00, 1'b0);
      wbyte("ro_d0", 8'hAA, 1'b0);
      wbyte("ro_d1", 8'hAA, 1'b0);
      stop_c();
      start_c();
      wbyte("ro_rd_addr_w", 8'h90, 1'b0);
      wbyte("ro_rd_ptr0", 8'h00, 1'b0);
      start_c();
      wbyte("ro_rd_addr_r", 8'h91, 1'b0);
      rbyte("ro_r0_b0", 8'h19, 1'b0);
      rbyte("ro_r0_b1", 8'h50, 1'b1);
      stop_c();

      // reset while the target drives a data bit
      start_c();
      wbyte("mid_addr_w", 8'h90, 1'b0);
      wbyte("mid_ptr0", 8'h00, 1'b0);
      start_c();
      wbyte("mid_addr_r", 8'h91, 1'b0);
      check("mid_oe_driving", {31'd0, sda_oe}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_oe", {31'd0, sda_oe}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      scl = 1'b1;
      sda_m = 1'b1;
      #23;
      rst_n = 1'b1;
      #(2*Q);
      start_c();
      wbyte("post_rst_addr", 8'h91, 1'b0);
      rbyte("post_rst_r0_b0", 8'h27, 1'b0);
      rbyte("post_rst_r0_b1", 8'h20, 1'b0);
      rbyte("post_rst_r1_b0", 8'h61, 1'b0);
      rbyte("post_rst_r1_b1", 8'hA0, 1'b1);
      stop_c();

      #(4*Q);
      check("exp_q_drained", exp_q.size(), 32'd0);
      check("wr_q_drained", wr_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
